// File: rtl/rca_seg_accum.sv
// Nibble-serial ripple-carry adder/accumulator with valid/ready input and a
// multiplexed common-anode hex display of the result. Optional: RCA_SEG_OVF_EN.
module rca_seg_accum #(
   parameter int WIDTH    = 8,
   parameter int SCAN_DIV = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 Ci,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     S,
   output logic                 Co,
   output logic                 out_valid,
   output logic                 ovf,
   output logic [WIDTH/4-1:0]   an,
   output logic [6:0]           seg,
   output logic                 dp
);
   // state   | meaning
   // IDLE    | waiting for operands, in_ready high
   // ADD     | one nibble summed per clock, lowest first

   localparam int NDIG = WIDTH / 4;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_ADD  = 1'b1;

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
         $error("rca_seg_accum: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   logic             state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] part_next;
   logic             carry;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [4:0]       nsum;
   logic             last_nib;

   assign in_ready = (state == ST_IDLE);
   assign last_nib = (cnt == CW'(NDIG - 1));

   always_comb begin
      nib_a = op_a[cnt*4 +: 4];
      nib_b = op_b[cnt*4 +: 4];
      nsum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry};
      part_next = part;
      part_next[cnt*4 +: 4] = nsum[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         part      <= '0;
         carry     <= 1'b0;
         S         <= '0;
         Co        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_a  <= A;
                  // accumulate uses S as registered at the accept edge
                  op_b  <= mode ? S : B;
                  carry <= Ci;
                  cnt   <= '0;
                  state <= ST_ADD;
               end
            end
            default: begin
               part  <= part_next;
               carry <= nsum[4];
               cnt   <= cnt + 1'b1;
               if (last_nib) begin
                  S         <= part_next;
                  Co        <= nsum[4];
                  out_valid <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

`ifdef RCA_SEG_OVF_EN
   logic [3:0] low3_sum;
   logic       ovf_q;

   // carry into the top bit of the top nibble, i.e. into bit WIDTH-1
   assign low3_sum = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, carry};

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state == ST_ADD && last_nib) begin
         ovf_q <= low3_sum[3] ^ nsum[4];
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   logic [SCAN_DIV-1:0] pre;
   logic [CW-1:0]       dig;
   logic [3:0]          hex;

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         dig <= '0;
      end else begin
         pre <= pre + 1'b1;
         if (&pre) begin
            dig <= (dig == CW'(NDIG - 1)) ? '0 : dig + 1'b1;
         end
      end
   end

   always_comb begin
      hex = S[dig*4 +: 4];
      an  = ~(NDIG'(1) << dig);
      dp  = ~(Co && (dig == CW'(NDIG - 1)));
      case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
   end

endmodule

// File: tb/tb_rca_seg_accum.sv
// Scoreboard bench for rca_seg_accum at WIDTH=8, SCAN_DIV=2; expected results
// are queued at issue and popped by a monitor on each out_valid.
module tb_rca_seg_accum;
   localparam int WIDTH    = 8;
   localparam int SCAN_DIV = 2;
   localparam int NDIG     = WIDTH / 4;
`ifdef RCA_SEG_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] A, B;
   logic             Ci, mode, in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] S;
   logic             Co, out_valid, ovf;
   logic [NDIG-1:0]  an;
   logic [6:0]       seg;
   logic             dp;

   int tests = 0;
   int fails = 0;
   logic [9:0] exp_q[$];

   rca_seg_accum #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .Ci(Ci), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .S(S), .Co(Co),
      .out_valid(out_valid), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // monitor: every result pulse must match the oldest issued expectation
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out_valid: got S=%0h Co=%0b, expected no result", S, Co);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if ({S, Co, ovf} !== e) begin
               fails++;
               $display("FAIL result: got S=%0h Co=%0b ovf=%0b, expected S=%0h Co=%0b ovf=%0b",
                        S, Co, ovf, e[9:2], e[1], e[0]);
            end
         end
      end
   end

   // Called just after a negedge; returns at the negedge where out_valid is high,
   // so consecutive calls issue back-to-back.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic md, input logic [7:0] es, input logic eco,
                        input logic eovf);
      A = a; B = b; Ci = ci; mode = md; in_valid = 1'b1;
      exp_q.push_back({es, eco, eovf & OVF_ON});
      chk("ready_before_accept", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      A = ~a; B = ~b; Ci = ~ci;
      chk("ready_low_c1", in_ready, 1'b0);
      chk("no_valid_c1", out_valid, 1'b0);
      @(negedge clk);
      chk("ready_low_c2", in_ready, 1'b0);
      chk("no_valid_c2", out_valid, 1'b0);
      @(negedge clk);
      chk("valid_latency", out_valid, 1'b1);
      chk("ready_with_valid", in_ready, 1'b1);
   endtask

   task automatic wait_an(input logic [NDIG-1:0] want, input string name);
      int i;
      for (i = 0; i < 40 && an !== want; i++) @(negedge clk);
      chk(name, an, want);
   endtask

   initial begin
      rst = 1'b1; A = '0; B = '0; Ci = 1'b0; mode = 1'b0; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_S", S, 8'h00);
      chk("rst_Co", Co, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_an", an, 2'b10);
      chk("rst_seg", seg, 7'b1000000);
      chk("rst_dp", dp, 1'b1);

      do_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
      @(negedge clk);
      chk("valid_single_cycle", out_valid, 1'b0);

      do_op(8'hF8, 8'h19, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
      wait_an(2'b01, "dp_wait_hi");
      chk("dp_lit_hi_digit", dp, 1'b0);
      wait_an(2'b10, "dp_wait_lo");
      chk("dp_dark_lo_digit", dp, 1'b1);

      do_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      do_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
      do_op(8'hFA, 8'h55, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
      do_op(8'h01, 8'h77, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0);

      // in_valid held through ADD with A changing; only the first A counts
      @(negedge clk);
      A = 8'h10; B = 8'h20; Ci = 1'b0; mode = 1'b0; in_valid = 1'b1;
      exp_q.push_back({8'h30, 1'b0, 1'b0});
      @(negedge clk); A = 8'h41;
      @(negedge clk); A = 8'h52;
      chk("hold_no_early_valid", out_valid, 1'b0);
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("hold_S", S, 8'h30);

      // reset one cycle after accept aborts the operation
      A = 8'h21; B = 8'h22; Ci = 1'b1; mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_S", S, 8'h00);
      chk("abort_Co", Co, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_an", an, 2'b10);
      chk("abort_seg", seg, 7'b1000000);
      repeat (4) @(negedge clk);
      chk("abort_no_result", out_valid, 1'b0);

      do_op(8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
      wait_an(2'b01, "scan_sync");
      wait_an(2'b10, "scan_lo_start");
      for (int k = 0; k < 4; k++) begin
         chk("scan_lo_an", an, 2'b10);
         chk("scan_lo_seg", seg, 7'b1000110);
         @(negedge clk);
      end
      chk("scan_hi_an", an, 2'b01);
      chk("scan_hi_seg", seg, 7'b0110000);

      do_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      chk("ovf_level", ovf, OVF_ON);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/rca_seg_accum.md
# rca_seg_accum

Parametrised, nibble-serial ripple-carry adder/accumulator with a valid/ready operand handshake and a time-multiplexed hex seven-segment display driver. It is the next generation of the team's 4-bit RCA. It adds generic width, carry-in, an accumulate mode, a registered result with completion strobe, and on-board display of the result. It sits between the switch/button input logic and the board's common-anode seven-segment display.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and ≥ 4, else elaboration error; NDIG = WIDTH/4
- SCAN_DIV, 16, prescaler width; the display advances one digit every 2^SCAN_DIV clocks
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; ignored in accumulate mode
- Ci  in  1  carry-in
- mode  in  1  0 = S ← A+B+Ci; 1 = S ← S+A+Ci (accumulate)
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block idle, can accept
- S  out  WIDTH  registered sum
- Co  out  1  registered carry-out
- out_valid  out  1  one-cycle pulse when S/Co are updated
- ovf  out  1  signed overflow of last result (see Configuration)
- an  out  NDIG  digit enables, active-low, one-hot; bit k = hex digit k of S
- seg  out  7  segments active-low; seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low; lit only on digit NDIG-1 when Co=1

## Operation
- FSM states: IDLE, ADD.
- IDLE: in_ready=1. On in_valid && in_ready:
  - latch A, operand2 (B, or S when mode=1), and Ci;
  - clear nibble counter;
  - go to ADD.
- ADD: in_ready=0; in_valid is ignored and not queued.
  - Each clock adds nibble k of both operands plus the carry register.
  - Nibble sum k goes into a shift/partial register; the nibble carry goes into the carry register; k increments.
- After nibble NDIG-1:
  - S ← full partial sum, Co ← final carry;
  - ovf ← carry into bit WIDTH-1 XOR Co;
  - out_valid pulses; return to IDLE.
- S, Co and ovf hold between results. Partial sums are never visible on S or on the display.
- Arithmetic is modulo 2^WIDTH; the carry beyond WIDTH appears only on Co.
- Display scanner:
  - free-running prescaler;
  - on prescaler wrap, the digit index increments and wraps from NDIG-1 to 0;
  - seg shows the hex glyph (0–F, standard a–g patterns) of nibble [index] of S;
  - the scanner is independent of the FSM and updates immediately when S changes.
- Reset (including mid-ADD):
  - FSM → IDLE; the in-flight operation is aborted with no out_valid.
  - S=0, Co=0, ovf=0, out_valid=0, in_ready=1.
  - Prescaler=0, digit index=0: an has only bit 0 low, seg=7'b1000000 ("0"), dp=1.

## Timing
- Accept edge e0. ADD edges e1..eNDIG. S, Co, ovf and out_valid are registered at eNDIG.
- Latency: out_valid is high in the cycle after eNDIG, i.e. NDIG clocks after acceptance.
- in_ready is low from after e0 through eNDIG and high in the same cycle as out_valid.
- Back-to-back: a new operation can be accepted at edge eNDIG+1. Throughput is one result per NDIG+1 clocks.
- Accumulate operand: S as registered at the accept edge. Back-to-back accumulation therefore uses the just-completed result.
- Operands may change freely after acceptance.
- Digit dwell is exactly 2^SCAN_DIV clocks. A full refresh takes NDIG·2^SCAN_DIV clocks.

## Configuration
- RCA_SEG_OVF_EN defined: ovf is computed as above and registered with S.
- RCA_SEG_OVF_EN undefined: ovf is tied to 0 and no overflow logic is generated. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, SCAN_DIV=2 (NDIG=2).
- mode=0, A=0x05, B=0x03, Ci=0 → S=0x08, Co=0; out_valid 2 clocks after accept, single-cycle; in_ready low for 2 cycles.
- mode=0, A=0xF8, B=0x19, Ci=0 → S=0x11, Co=1, dp low while an=2'b01; then A=0xFF, B=0x00, Ci=1 → S=0x00, Co=1.
- From S=0x08: mode=1, A=0xFA, Ci=0 → S=0x02, Co=1. Immediately, mode=1, A=0x01, Ci=1 → S=0x04, Co=0.
- in_valid held high during ADD with A changing each cycle → only the accepted A is summed; exactly one out_valid per accept.
- rst asserted one cycle after accept → no out_valid. The next cycle shows S=0, Co=0, in_ready=1, an=2'b10, seg=7'b1000000.
- Display and overflow:
  - S=0x3C → an=2'b10 with seg=7'b1000110 ("C") for 4 clocks, then an=2'b01 with seg=7'b0110000 ("3").
  - With RCA_SEG_OVF_EN, A=0x7F, B=0x01 → S=0x80, ovf=1.
  - Without RCA_SEG_OVF_EN, the same stimulus gives ovf=0.
